// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: next-PC select encoding, fetch FSM states and
// reset-vector constant, plus the jump-target concatenation helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_op_t;

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_REQ   = 2'b01,
    S_VALID = 2'b10,
    S_HALT  = 2'b11
  } ifu_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // J-type target: keep the 256 MB region of the delay-slot address.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] instr_idx);
    return {pc_plus4[31:28], instr_idx, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// Combinational next-PC selection for the fetch unit (module npc_calc).
// Branch offsets are word offsets, sign-extended upstream by the extend unit.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [1:0]  npc_op_i,
  input  logic        branch_taken_i,
  input  logic [31:0] ext_out_i,
  input  logic [25:0] instr_idx_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] npc_o
);

  logic signed [31:0] br_off;
  logic [31:0]        br_target;

  assign br_off    = signed'(ext_out_i) <<< 2;
  assign br_target = pc_plus4_i + unsigned'(br_off);

  always_comb begin
    npc_o = pc_plus4_i;
    case (npc_op_t'(npc_op_i))
      NPC_SEQ:    npc_o = pc_plus4_i;
      NPC_BRANCH: npc_o = branch_taken_i ? br_target : pc_plus4_i;
      NPC_JUMP:   npc_o = jump_target(pc_plus4_i, instr_idx_i);
      NPC_JR:     npc_o = jr_target_i;
      default:    npc_o = pc_plus4_i;
    endcase
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, imem request/ack handshake, next-PC update.
// Optional misaligned-JR trap enabled by defining IFU_MISALIGN_TRAP_EN.
module ifu_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [15:0] imm16,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        branch_taken,
  input  logic [31:0] ext_out,
  input  logic [31:0] jr_target,
  output logic        misalign_fault
);

  ifu_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_w;
  logic [31:0] npc_w;

  assign pc_plus4_w = pc_q + 32'd4;

  npc_calc u_npc_calc (
    .pc_plus4_i     (pc_plus4_w),
    .npc_op_i       (npc_op),
    .branch_taken_i (branch_taken),
    .ext_out_i      (ext_out),
    .instr_idx_i    (instr_q[25:0]),
    .jr_target_i    (jr_target),
    .npc_o          (npc_w)
  );

`ifdef IFU_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall) begin
          // Only JR can land here misaligned; the PC keeps the offending JR address.
          if (npc_w[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = npc_w;
            state_d = S_REQ;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign misalign_fault = fault_q;
`else
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall) begin
          pc_d    = npc_w & ~32'd3;
          state_d = S_REQ;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  assign misalign_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign instr_valid = (state_q == S_VALID);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign instr       = instr_q;
  assign imm16       = instr_q[15:0];

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboarded bench for ifu_fetch: expected fetch addresses are queued when a
// retire is driven and popped when the DUT raises imem_req.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [1:0]  OP_SEQ = 2'b00;
  localparam logic [1:0]  OP_BR  = 2'b01;
  localparam logic [1:0]  OP_J   = 2'b10;
  localparam logic [1:0]  OP_JR  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [15:0] imm16;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic [1:0]  npc_op;
  logic        branch_taken;
  logic [31:0] ext_out;
  logic [31:0] jr_target;
  logic        misalign_fault;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .imm16          (imm16),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .stall          (stall),
    .npc_op         (npc_op),
    .branch_taken   (branch_taken),
    .ext_out        (ext_out),
    .jr_target      (jr_target),
    .misalign_fault (misalign_fault)
  );

  // Waits for a request, pops the expected address, acks after 'delay' cycles.
  task automatic do_fetch(input logic [31:0] data, input int delay);
    logic [31:0] exp;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL fetch_req_timeout imem_req=%b want 1", imem_req);
      return;
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty imem_addr=%h with no expected address", imem_addr);
      return;
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (imem_addr !== exp) begin
      n_err++;
      $display("FAIL fetch_addr got %h want %h", imem_addr, exp);
    end
    for (int d = 0; d < delay; d++) begin
      n_cmp++;
      if (instr_valid !== 1'b0 || imem_addr !== exp || imem_req !== 1'b1) begin
        n_err++;
        $display("FAIL wait_ack cyc%0d valid=%b addr=%h req=%b want 0/%h/1",
                 d, instr_valid, imem_addr, imem_req, exp);
      end
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr !== data || pc !== exp || imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL fetched valid=%b instr=%h pc=%h req=%b want 1/%h/%h/0",
               instr_valid, instr, pc, imem_req, data, exp);
    end
  endtask

  // Drives the next-PC controls for the S_VALID cycle and releases stall.
  task automatic retire(input logic [1:0] op, input logic taken, input logic [31:0] ext,
                        input logic [31:0] jr, input bit push, input logic [31:0] exp);
    npc_op       = op;
    branch_taken = taken;
    ext_out      = ext;
    jr_target    = jr;
    stall        = 1'b0;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    npc_op       = OP_SEQ;
    branch_taken = 1'b1;
    ext_out      = $urandom();
    jr_target    = $urandom();
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    stall    = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (pc !== RST_PC || instr !== 32'd0 || instr_valid !== 1'b0 ||
        imem_req !== 1'b0 || misalign_fault !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values pc=%h instr=%h valid=%b req=%b fault=%b",
               pc, instr, instr_valid, imem_req, misalign_fault);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_req got %b want 0", imem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL req_after_reset got %b want 1", imem_req);
    end
    exp_q.push_back(RST_PC);
  endtask

  task automatic test_immediate_ack();
    do_fetch(32'h2008_FFFC, 0);
    n_cmp++;
    if (imm16 !== 16'hFFFC || pc_plus4 !== 32'h3004) begin
      n_err++;
      $display("FAIL imm16_pc4 imm16=%h pc_plus4=%h want fffc/3004", imm16, pc_plus4);
    end
    retire(OP_SEQ, 1'b1, 32'h10, 32'h0, 1'b1, 32'h3004);
  endtask

  task automatic test_delayed_ack();
    do_fetch(32'h0000_0001, 3);
    retire(OP_SEQ, 1'b0, 32'h0, 32'h0, 1'b1, 32'h3008);
  endtask

  task automatic test_stall();
    stall = 1'b1;
    do_fetch(32'h1234_5678, 0);
    for (int c = 0; c < 4; c++) begin
      imem_ack   = (c == 1);
      imem_rdata = 32'hDEAD_BEEF;
      npc_op     = OP_JR;
      jr_target  = 32'h0000_7000;
      @(negedge clk);
      n_cmp++;
      if (pc !== 32'h3008 || instr !== 32'h1234_5678 || instr_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold cyc%0d pc=%h instr=%h valid=%b want 3008/12345678/1",
                 c, pc, instr, instr_valid);
      end
    end
    imem_ack = 1'b0;
    retire(OP_SEQ, 1'b0, 32'h0, 32'h0, 1'b1, 32'h300C);
  endtask

  task automatic test_branch();
    do_fetch(32'h0000_0002, 1);
    retire(OP_SEQ, 1'b0, 32'h0, 32'h0, 1'b1, 32'h3010);
    do_fetch(32'h1000_FFFF, 0);
    retire(OP_BR, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h3004);
    do_fetch(32'h0000_0003, 0);
    retire(OP_JR, 1'b0, 32'h0, 32'h0000_3010, 1'b1, 32'h3010);
    do_fetch(32'h1000_FFFF, 2);
    retire(OP_BR, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h3014);
  endtask

  task automatic test_jump();
    do_fetch(32'h0000_0004, 0);
    retire(OP_JR, 1'b0, 32'h0, 32'h0000_3000, 1'b1, 32'h3000);
    do_fetch(32'h0800_0C10, 0);
    retire(OP_J, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_3040);
  endtask

  task automatic test_wrap();
    do_fetch(32'h0000_0005, 0);
    retire(OP_JR, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0006, 0);
    n_cmp++;
    if (pc_plus4 !== 32'h0) begin
      n_err++;
      $display("FAIL pc_plus4_wrap got %h want 00000000", pc_plus4);
    end
    retire(OP_SEQ, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    do_fetch(32'h0000_0007, 0);
  endtask

  task automatic test_misalign();
`ifdef IFU_MISALIGN_TRAP_EN
    retire(OP_JR, 1'b0, 32'h0, 32'h0000_3002, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (misalign_fault !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL misalign_halt cyc%0d fault=%b pc=%h req=%b valid=%b want 1/0/0/0",
                 c, misalign_fault, pc, imem_req, instr_valid);
      end
      imem_ack = (c == 1);
      @(negedge clk);
    end
    imem_ack = 1'b0;
`else
    retire(OP_JR, 1'b0, 32'h0, 32'h0000_3002, 1'b1, 32'h3000);
    do_fetch(32'h0000_0008, 0);
    n_cmp++;
    if (misalign_fault !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_tied got %b want 0", misalign_fault);
    end
    stall = 1'b1;
`endif
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] exp;
    test_reset();
    do_fetch(32'h0000_0009, 0);
    retire(OP_SEQ, 1'b0, 32'h0, 32'h0, 1'b1, 32'h3004);
    exp = exp_q.pop_front();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== exp) begin
      n_err++;
      $display("FAIL pre_abort req=%b addr=%h want 1/%h", imem_req, imem_addr, exp);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    rst_n      = 1'b0;
    #1;
    n_cmp++;
    if (pc !== RST_PC || imem_req !== 1'b0 || instr !== 32'd0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_abort pc=%h req=%b instr=%h valid=%b want %h/0/0/0",
               pc, imem_req, instr, instr_valid, RST_PC);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    exp_q.push_back(RST_PC);
    @(negedge clk);
    do_fetch(32'h0000_000A, 0);
    stall = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    stall        = 1'b0;
    npc_op       = OP_SEQ;
    branch_taken = 1'b0;
    ext_out      = 32'h0;
    jr_target    = 32'h0;
    test_reset();
    test_immediate_ack();
    test_delayed_ack();
    test_stall();
    test_branch();
    test_jump();
    test_wrap();
    test_misalign();
    test_reset_mid_req();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit of the single-cycle CPU datapath, directly upstream of the immediate extend unit. Holds the PC, fetches each instruction from instruction memory over a request/acknowledge handshake, presents the instruction and its `imm16` field to decode and the extend unit, and computes the next PC. For branches it takes the sign-extended offset produced by the extend unit.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_3000`: PC value loaded on reset.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `imem_req`, output, 1: fetch request.
- `imem_addr`, output, 32: fetch address; equals `pc`.
- `imem_ack`, input, 1: memory has `imem_rdata` valid this cycle.
- `imem_rdata`, input, 32: fetched word.
- `instr`, output, 32: registered instruction.
- `imm16`, output, 16: `instr[15:0]`; feeds the extend unit.
- `instr_valid`, output, 1: `instr` is valid for execution.
- `pc`, output, 32: address of `instr`.
- `pc_plus4`, output, 32: `pc + 4`.
- `stall`, input, 1: hold the current instruction.
- `npc_op`, input, 2: next-PC select. 00 = SEQ, 01 = BRANCH, 10 = JUMP, 11 = JR.
- `branch_taken`, input, 1: branch condition from the ALU.
- `ext_out`, input, 32: extended immediate from the extend unit.
- `jr_target`, input, 32: register-file value for JR.
- `misalign_fault`, output, 1: sticky misaligned-target flag.

## Operation
- FSM states: S_RESET, S_REQ, S_VALID, S_HALT.
- Reset values:
  - state = S_RESET; `pc` = `RESET_PC`; `instr` = 0.
  - `instr_valid` = 0; `imem_req` = 0; `misalign_fault` = 0.
- S_RESET leads to S_REQ unconditionally on the first edge after `rst_n` rises.
- S_REQ:
  - `imem_req` = 1; `imem_addr` = `pc`, held stable.
  - On an edge with `imem_ack` = 1: `instr` <= `imem_rdata`, go to S_VALID.
  - Otherwise stay in S_REQ; waits indefinitely.
- S_VALID:
  - `instr_valid` = 1; `imem_req` = 0.
  - If `stall` = 1: hold all state.
  - If `stall` = 0: `pc` <= npc, go to S_REQ.
- `imem_ack` outside S_REQ is ignored.
- `npc_op`, `branch_taken`, `ext_out` and `jr_target` are sampled only in S_VALID with `stall` = 0.
- npc, all arithmetic modulo 2^32 with silent wrap:
  - SEQ: `pc_plus4`.
  - BRANCH: `pc_plus4 + (ext_out << 2)` if `branch_taken`, else `pc_plus4`.
  - JUMP: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - JR: `jr_target`.
- `rst_n` low in any state, including mid-handshake, aborts immediately to reset values. A pending `imem_ack` is dropped.

## Timing
- Minimum 2 cycles per instruction: S_REQ with ack in the same cycle, then S_VALID.
- `instr_valid` rises one cycle after the acking edge. It falls on the cycle after the edge where `stall` = 0.
- `imem_req` rises the cycle after `rst_n` deasserts plus one edge (S_RESET lasts exactly one cycle).
- `pc`, `pc_plus4`, `instr` and `imm16` are stable for the whole time `instr_valid` = 1.
- The extend unit is combinational. `ext_out` must settle within the S_VALID cycle in which it is sampled.

## Configuration
- Macro `IFU_MISALIGN_TRAP_EN`.
- Defined:
  - If the computed npc has `npc[1:0]` ≠ 0 at an S_VALID, `stall` = 0 edge, `pc` is not updated.
  - `misalign_fault` <= 1 and the FSM enters S_HALT.
  - In S_HALT, `imem_req` = 0 and `instr_valid` = 0. Only reset exits.
  - Only JR can trigger this; BRANCH and JUMP are always aligned.
- Undefined: `npc[1:0]` is forced to 00, `misalign_fault` is tied to 0, and S_HALT is unreachable.

## Structure
- Shared package `cpu_pkg` holds:
  - `npc_op_t` enum: SEQ, BRANCH, JUMP, JR.
  - `ifu_state_t` enum.
  - Constant `DEFAULT_RESET_PC` = `32'h0000_3000`.
- One combinational sub-module, `npc_calc`:
  - Inputs: `pc_plus4`, `npc_op`, `branch_taken`, `ext_out`, `instr[25:0]`, `jr_target`.
  - Output: npc.
- `ifu_fetch` holds the FSM and registers.

## Test plan
- Reset then immediate ack:
  - `imem_req` = 1 at cycle 1 with `imem_addr` = `32'h3000`.
  - Ack with `32'h2008_FFFC` gives `instr_valid` = 1 next cycle and `imm16` = `16'hFFFC`.
- Ack delayed 3 cycles: `imem_addr` holds `32'h3000` throughout and `instr_valid` stays 0 until after the ack.
- Stall held 4 cycles in S_VALID: `pc`, `instr` and `instr_valid` unchanged. Release with SEQ gives next `imem_addr` = `32'h3004`.
- BRANCH at `pc` = `32'h3010`, `branch_taken` = 1, `ext_out` = `32'hFFFF_FFFC`: next `pc` = `32'h3004`. With `branch_taken` = 0: next `pc` = `32'h3014`.
- JUMP with `instr[25:0]` = `26'h0000C10` at `pc` = `32'h3000`: next `pc` = `32'h0000_3040`. JR with `jr_target` = `32'hFFFF_FFFC` plus SEQ afterwards: `pc` wraps to 0.
- JR with `jr_target` = `32'h3002`:
  - Macro defined: `misalign_fault` = 1, `pc` stays at the JR address, `imem_req` = 0 until reset.
  - Macro undefined: next `pc` = `32'h3000`.
  - Separately, `rst_n` pulsed low mid-S_REQ restores `pc` = `RESET_PC`.
